// File: rtl/glip_pkg.sv
// Shared GLIP helpers: counter-width function and width-converter limits.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package glip_pkg;

    // Largest supported upscale factor; bounds the lane counter width.
    localparam int GLIP_UPSCALE_FACTOR_MAX = 16;

    // Bits needed to count 0..value-1, never less than one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/glip_upscale_n.sv
// Width upscaler: packs FACTOR IN_SIZE-bit words into one IN_SIZE*FACTOR-bit word.
// Latency: out_valid rises the cycle after the closing input word transfers.
// Backpressure: in_ready = !out_valid | out_ready; output held stable while stalled.
//
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready narrow side;
// out_data/out_keep/out_last/out_valid/out_ready wide side.
// Optional feature macro GLIP_UPSCALE_LAST_EN: in_last closes a partial word early,
// reported through out_keep/out_last. Without it in_last is ignored and only full
// words are produced.
module glip_upscale_n
    import glip_pkg::*;
#(
    parameter int IN_SIZE   = 8,
    parameter int FACTOR    = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [IN_SIZE-1:0]        in_data,
    input  logic                      in_valid,
    input  logic                      in_last,
    output logic                      in_ready,
    output logic [IN_SIZE*FACTOR-1:0] out_data,
    output logic [FACTOR-1:0]         out_keep,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready
);

    localparam int CNT_WIDTH = clog2(FACTOR);
    localparam int OUT_SIZE  = IN_SIZE * FACTOR;
    localparam int ACC_SIZE  = IN_SIZE * (FACTOR - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(FACTOR - 1);

    generate
        if (FACTOR < 2 || FACTOR > GLIP_UPSCALE_FACTOR_MAX) begin : g_bad_factor
            $error("glip_upscale_n: FACTOR must be in 2..16");
        end
    endgenerate

    // Output lane taken by the k-th word of a group.
    function automatic int lane_of(input int k);
        return MSB_FIRST ? (FACTOR - 1 - k) : k;
    endfunction

    // acc holds words in arrival order (slot k = k-th word); lane placement
    // happens only when the output word is assembled.
    logic [ACC_SIZE-1:0]  acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [OUT_SIZE-1:0]  acc_ext;
    logic [OUT_SIZE-1:0]  asm_data;
    logic [FACTOR-1:0]    asm_keep;
    logic                 flush;
    logic                 closing;
    logic                 in_xfer;
    logic                 out_xfer;

`ifdef GLIP_UPSCALE_LAST_EN
    assign flush = in_last;
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign flush          = 1'b0;
`endif

    // Pad with a zero slot so the assembly loop can index every word position.
    assign acc_ext  = {{IN_SIZE{1'b0}}, acc};

    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    assign closing  = (cnt == CNT_LAST) || flush;

    // Candidate output word: stored slots below cnt, current word at cnt,
    // untouched lanes zero with keep cleared.
    always_comb begin
        asm_data = '0;
        asm_keep = '0;
        for (int k = 0; k < FACTOR; k++) begin
            if (k < int'(cnt)) begin
                asm_data[lane_of(k)*IN_SIZE +: IN_SIZE] = acc_ext[k*IN_SIZE +: IN_SIZE];
                asm_keep[lane_of(k)] = 1'b1;
            end else if (k == int'(cnt)) begin
                asm_data[lane_of(k)*IN_SIZE +: IN_SIZE] = in_data;
                asm_keep[lane_of(k)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_xfer) begin
                out_valid <= 1'b0;
            end
            if (in_xfer) begin
                if (closing) begin
                    // Overrides the drain above when both happen together.
                    out_data  <= asm_data;
                    out_keep  <= asm_keep;
                    out_last  <= flush;
                    out_valid <= 1'b1;
                    cnt       <= '0;
                    acc       <= '0;
                end else begin
                    for (int k = 0; k < FACTOR - 1; k++) begin
                        if (cnt == CNT_WIDTH'(k)) begin
                            acc[k*IN_SIZE +: IN_SIZE] <= in_data;
                        end
                    end
                    cnt <= cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
